// File: rtl/mem_io_responder.sv
//------------------------------------------------------------------------------
// mem_io_responder: byte RAM plus memory-mapped UART FIFOs, cycle counter and
// program-stop flag on the CPU byte bus.  Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_io_responder #(
  parameter int RAM_AW        = 17,
  parameter int RX_DEPTH_LOG2 = 3,
  parameter int TX_DEPTH_LOG2 = 3
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  mem_din,
  output logic        cpu_rdy_out,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  output logic        program_stop
);

  localparam int c_RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int c_TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int c_RAM_DEPTH = 1 << RAM_AW;

  // Address decode
  logic              w_io_sel;
  logic [2:0]        w_reg_sel;
  logic              w_uart_sel;
  logic              w_cnt_sel;
  logic [RAM_AW-1:0] w_ram_addr;
  logic              w_unused_addr;

  assign w_io_sel      = (mem_a[17:16] == 2'b11);
  assign w_reg_sel     = mem_a[2:0];
  assign w_uart_sel    = w_io_sel && (w_reg_sel == 3'd0);
  assign w_cnt_sel     = w_io_sel && (w_reg_sel == 3'd4);
  assign w_ram_addr    = mem_a[RAM_AW-1:0];
  assign w_unused_addr = ^mem_a[31:18];

  // FIFO state
  logic [RX_DEPTH_LOG2:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [TX_DEPTH_LOG2:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [7:0]             rx_mem [0:c_RX_DEPTH-1];
  logic [7:0]             tx_mem [0:c_TX_DEPTH-1];
  logic                   w_rx_empty, w_rx_full, w_tx_empty, w_tx_full;
  logic                   w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
  logic [7:0]             w_rx_head;

  assign w_rx_empty = (rx_wp_q == rx_rp_q);
  assign w_rx_full  = (rx_wp_q[RX_DEPTH_LOG2] != rx_rp_q[RX_DEPTH_LOG2]) &&
                      (rx_wp_q[RX_DEPTH_LOG2-1:0] == rx_rp_q[RX_DEPTH_LOG2-1:0]);
  assign w_tx_empty = (tx_wp_q == tx_rp_q);
  assign w_tx_full  = (tx_wp_q[TX_DEPTH_LOG2] != tx_rp_q[TX_DEPTH_LOG2]) &&
                      (tx_wp_q[TX_DEPTH_LOG2-1:0] == tx_rp_q[TX_DEPTH_LOG2-1:0]);
  assign w_rx_head  = rx_mem[rx_rp_q[RX_DEPTH_LOG2-1:0]];

  assign rx_ready = !w_rx_full;
  assign tx_valid = !w_tx_empty;
  assign tx_data  = tx_mem[tx_rp_q[TX_DEPTH_LOG2-1:0]];

  // Stall only when a transmit write meets a full FIFO that is not draining now
  logic w_tx_wr_req;
  logic w_acc_rd, w_acc_wr;

  assign w_tx_wr_req = mem_wr && ((w_uart_sel && (cpu_dout != 8'h00)) || w_cnt_sel);
  assign w_tx_pop    = !w_tx_empty && tx_ready;
  assign cpu_rdy_out = !(w_tx_wr_req && w_tx_full && !w_tx_pop);
  assign w_acc_rd    = cpu_rdy_out && !mem_wr;
  assign w_acc_wr    = cpu_rdy_out && mem_wr;

  assign w_rx_push = rx_valid && !w_rx_full;
  assign w_rx_pop  = w_acc_rd && w_uart_sel && !w_rx_empty;
  assign w_tx_push = w_acc_wr && w_tx_wr_req;

  always_comb begin
    rx_wp_d = rx_wp_q;
    rx_rp_d = rx_rp_q;
    tx_wp_d = tx_wp_q;
    tx_rp_d = tx_rp_q;
    if (w_rx_push) rx_wp_d = rx_wp_q + {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
    if (w_rx_pop)  rx_rp_d = rx_rp_q + {{RX_DEPTH_LOG2{1'b0}}, 1'b1};
    if (w_tx_push) tx_wp_d = tx_wp_q + {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
    if (w_tx_pop)  tx_rp_d = tx_rp_q + {{TX_DEPTH_LOG2{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk_in) begin
    if (w_rx_push) rx_mem[rx_wp_q[RX_DEPTH_LOG2-1:0]] <= rx_data;
    if (w_tx_push) tx_mem[tx_wp_q[TX_DEPTH_LOG2-1:0]] <= w_cnt_sel ? 8'h00 : cpu_dout;
  end

  // Counter, snapshot and I/O read data
  logic [31:0] cnt_q;
  logic [23:0] snap_q;
  logic [7:0]  io_rdata_q, w_io_rdata;
  logic        rd_ram_q;
  logic        stop_q;

  always_comb begin
    w_io_rdata = 8'h00;
    case (w_reg_sel)
      3'd0:    w_io_rdata = w_rx_empty ? 8'h00 : w_rx_head;
      3'd4:    w_io_rdata = cnt_q[7:0];
      3'd5:    w_io_rdata = snap_q[7:0];
      3'd6:    w_io_rdata = snap_q[15:8];
      3'd7:    w_io_rdata = snap_q[23:16];
      default: w_io_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rx_wp_q    <= '0;
      rx_rp_q    <= '0;
      tx_wp_q    <= '0;
      tx_rp_q    <= '0;
      cnt_q      <= 32'h0;
      snap_q     <= 24'h0;
      io_rdata_q <= 8'h00;
      rd_ram_q   <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      rx_wp_q <= rx_wp_d;
      rx_rp_q <= rx_rp_d;
      tx_wp_q <= tx_wp_d;
      tx_rp_q <= tx_rp_d;
      cnt_q   <= cnt_q + 32'h1;
      if (w_acc_rd) begin
        rd_ram_q   <= !w_io_sel;
        io_rdata_q <= w_io_rdata;
        if (w_cnt_sel) snap_q <= cnt_q[31:8];
      end
      if (w_acc_wr && w_cnt_sel) stop_q <= 1'b1;
    end
  end

  // Byte RAM: unreset storage with a registered, enable-held read port
  logic [7:0] ram_mem [0:c_RAM_DEPTH-1];
  logic [7:0] ram_rdata_q;

  always_ff @(posedge clk_in) begin
    if (w_acc_wr && !w_io_sel) ram_mem[w_ram_addr] <= cpu_dout;
    if (w_acc_rd && !w_io_sel) ram_rdata_q <= ram_mem[w_ram_addr];
  end

  assign mem_din      = rd_ram_q ? ram_rdata_q : io_rdata_q;
  assign program_stop = stop_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_io_responder.sv
// Directed self-checking bench for mem_io_responder.
`default_nettype none

module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  mem_din;
  logic        cpu_rdy_out;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        program_stop;

  int n_pass = 0;
  int n_chk  = 0;
  int n_pop;

  mem_io_responder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .mem_a        (mem_a),
    .mem_wr       (mem_wr),
    .cpu_dout     (cpu_dout),
    .mem_din      (mem_din),
    .cpu_rdy_out  (cpu_rdy_out),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .rx_ready     (rx_ready),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .program_stop (program_stop)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drv(input logic wr, input logic [31:0] a, input logic [7:0] d);
    mem_wr   = wr;
    mem_a    = a;
    cpu_dout = d;
  endtask

  initial begin
    rst_in   = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tx_ready = 1'b0;
    drv(1'b0, 32'h30001, 8'h00);
    repeat (3) step();
    check("rst_mem_din", {24'h0, mem_din}, 32'h0);
    check("rst_rdy", {31'h0, cpu_rdy_out}, 32'h1);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("rst_stop", {31'h0, program_stop}, 32'h0);

    // Counter: 256 edges after release the counter reads 0x00000100
    rst_in = 1'b1;
    repeat (256) step();
    drv(1'b0, 32'h30004, 8'h00); step();
    check("cnt_b0", {24'h0, mem_din}, 32'h00);
    drv(1'b0, 32'h30005, 8'h00); step();
    check("cnt_b1", {24'h0, mem_din}, 32'h01);
    drv(1'b0, 32'h30006, 8'h00); step();
    check("cnt_b2", {24'h0, mem_din}, 32'h00);
    drv(1'b0, 32'h30007, 8'h00); step();
    check("cnt_b3", {24'h0, mem_din}, 32'h00);
    drv(1'b0, 32'h30004, 8'h00); step();
    check("cnt_b0_again", {24'h0, mem_din}, 32'h04);

    // RAM write then read, one-cycle latency
    drv(1'b1, 32'h01234, 8'h5A); step();
    drv(1'b1, 32'h1FFFF, 8'hC3); step();
    drv(1'b0, 32'h01234, 8'h00); step();
    check("ram_rd_1234", {24'h0, mem_din}, 32'h5A);
    drv(1'b0, 32'h1FFFF, 8'h00); #1;
    check("ram_latency", {24'h0, mem_din}, 32'h5A);
    step();
    check("ram_rd_1ffff", {24'h0, mem_din}, 32'hC3);
    drv(1'b1, 32'h00010, 8'h11); step();
    check("wr_holds_din", {24'h0, mem_din}, 32'hC3);

    // RX path
    drv(1'b0, 32'h30001, 8'h00);
    rx_valid = 1'b1; rx_data = 8'h41; step();
    rx_data = 8'h42; step();
    rx_valid = 1'b0;
    drv(1'b0, 32'h30000, 8'h00); step();
    check("rx_rd0", {24'h0, mem_din}, 32'h41);
    step();
    check("rx_rd1", {24'h0, mem_din}, 32'h42);
    step();
    check("rx_rd_empty", {24'h0, mem_din}, 32'h00);
    rx_valid = 1'b1; rx_data = 8'h77; step();
    check("rx_same_cycle", {24'h0, mem_din}, 32'h00);
    rx_valid = 1'b0; step();
    check("rx_rd_77", {24'h0, mem_din}, 32'h77);
    drv(1'b0, 32'h30001, 8'h00);
    rx_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rx_data = 8'h10 + 8'(i);
      step();
    end
    check("rx_full", {31'h0, rx_ready}, 32'h0);
    rx_data = 8'hEE; step();
    rx_valid = 1'b0;
    drv(1'b0, 32'h30000, 8'h00); step();
    check("rx_head_after_full", {24'h0, mem_din}, 32'h10);
    check("rx_ready_again", {31'h0, rx_ready}, 32'h1);
    drv(1'b0, 32'h30001, 8'h00); step();

    // TX path
    tx_ready = 1'b1;
    drv(1'b1, 32'h30000, 8'h48); step();
    check("tx_48_valid", {31'h0, tx_valid}, 32'h1);
    check("tx_48_data", {24'h0, tx_data}, 32'h48);
    drv(1'b1, 32'h30000, 8'h00); step();
    check("tx_zero_ignored", {31'h0, tx_valid}, 32'h0);
    drv(1'b1, 32'h30000, 8'h49); step();
    check("tx_49_data", {24'h0, tx_data}, 32'h49);
    drv(1'b0, 32'h30001, 8'h00); step();
    check("tx_drained", {31'h0, tx_valid}, 32'h0);

    // Stall on full TX FIFO
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drv(1'b1, 32'h30000, 8'h61); #1;
      check("tx_fill_rdy", {31'h0, cpu_rdy_out}, 32'h1);
      step();
    end
    drv(1'b1, 32'h30000, 8'h61); #1;
    check("stall_rdy0", {31'h0, cpu_rdy_out}, 32'h0);
    step();
    check("stall_holds", {31'h0, cpu_rdy_out}, 32'h0);
    tx_ready = 1'b1; #1;
    check("stall_release", {31'h0, cpu_rdy_out}, 32'h1);
    step();
    tx_ready = 1'b0; #1;
    check("stall_still_full", {31'h0, cpu_rdy_out}, 32'h0);
    drv(1'b1, 32'h30003, 8'h61); #1;
    check("reserved_no_stall", {31'h0, cpu_rdy_out}, 32'h1);
    drv(1'b0, 32'h30001, 8'h00);
    tx_ready = 1'b1;
    n_pop = 0;
    while (tx_valid && n_pop < 20) begin
      step();
      n_pop++;
    end
    check("tx_entries", n_pop, 32'd8);
    tx_ready = 1'b0;

    // Program stop, then reset in the middle of a read
    drv(1'b1, 32'h30004, 8'hAB); step();
    check("stop_set", {31'h0, program_stop}, 32'h1);
    check("stop_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("stop_tx_data", {24'h0, tx_data}, 32'h00);
    drv(1'b1, 32'h30001, 8'h99); step();
    check("stop_sticky", {31'h0, program_stop}, 32'h1);
    rx_valid = 1'b1; rx_data = 8'h55;
    drv(1'b0, 32'h01234, 8'h00); step();
    rx_valid = 1'b0;
    check("ram_before_rst", {24'h0, mem_din}, 32'h5A);
    drv(1'b0, 32'h30000, 8'h00); #2;
    rst_in = 1'b0; #1;
    check("midrst_mem_din", {24'h0, mem_din}, 32'h0);
    check("midrst_stop", {31'h0, program_stop}, 32'h0);
    check("midrst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("midrst_rx_ready", {31'h0, rx_ready}, 32'h1);
    check("midrst_rdy", {31'h0, cpu_rdy_out}, 32'h1);
    step();
    rst_in = 1'b1;
    step();
    check("post_rst_rx_empty", {24'h0, mem_din}, 32'h00);
    drv(1'b0, 32'h01234, 8'h00); step();
    check("ram_kept", {24'h0, mem_din}, 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
